neuron_mac: RTL and testbench

//   Serial multiply-accumulate neuron fed directly by the shifter stage: consumes one

---
 rtl/neuron_mac.sv | 144 ++++++++++++++
 tb/tb_neuron_mac.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Serial multiply-accumulate neuron: accumulates LEN weighted activations, adds bias,
// rescales, saturates (optional ReLU) and emits a one-cycle out_valid pulse.
module neuron_mac #(
    parameter int N    = 16,
    parameter int LEN  = 3,
    parameter int FRAC = 8,
    parameter int RELU = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [N-1:0]          x,
    input  logic [LEN-1:0][N-1:0] weights,
    input  logic [N-1:0]          bias,
    output logic [N-1:0]          out,
    output logic                  out_valid,
    output logic                  busy
);

    // Headroom for LEN full-scale products plus the scaled bias without wrapping.
    localparam int AW = 2*N + $clog2(LEN) + 1;
    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                 state_q;
    logic [IW-1:0]          idx_q;
    logic signed [AW-1:0]   acc_q;
    logic [N-1:0]           out_q;
    logic                   out_valid_q;
    logic                   busy_q;

    logic signed [N-1:0]    w_sel_s;
    logic signed [2*N-1:0]  prod_s;
    logic signed [AW-1:0]   acc_d;
    logic signed [AW-1:0]   bias_ext_s;
    logic signed [AW-1:0]   sum_s;
    logic signed [AW-1:0]   shr_s;
    logic [N-1:0]           result_s;

    // Clamp a wide signed value into the N-bit range, then optionally drop negatives.
    function automatic logic [N-1:0] sat_relu(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] max_v;
        logic signed [AW-1:0] min_v;
        logic [N-1:0]         sat;
        max_v = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
        min_v = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};
        if (v > max_v) begin
            sat = max_v[N-1:0];
        end else if (v < min_v) begin
            sat = min_v[N-1:0];
        end else begin
            sat = v[N-1:0];
        end
        if ((RELU != 0) && sat[N-1]) begin
            sat = {N{1'b0}};
        end else begin
            sat = sat;
        end
        return sat;
    endfunction

    // Datapath: current product, next accumulator and the rescaled, saturated result.
    always_comb begin
        w_sel_s    = $signed(weights[idx_q]);
        prod_s     = w_sel_s * $signed(x);
        acc_d      = acc_q + {{(AW-2*N){prod_s[2*N-1]}}, prod_s};
        bias_ext_s = {{(AW-N){bias[N-1]}}, bias};
        sum_s      = acc_q + (bias_ext_s <<< FRAC);
        shr_s      = sum_s >>> FRAC;
        result_s   = sat_relu(shr_s);
    end

    // Control FSM with registered outputs; start always wins over a same-cycle sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_ACCUM;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (start) begin
                        acc_q   <= '0;
                        idx_q   <= '0;
                    end else if (in_valid) begin
                        acc_q <= acc_d;
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= S_FINISH;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        acc_q <= acc_q;
                    end
                end
                S_FINISH: begin
                    if (start) begin
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_ACCUM;
                    end else begin
                        out_q       <= result_s;
                        out_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    idx_q   <= '0;
                    acc_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: two instances (ReLU on/off) share stimulus; a
// monitor pops expected results and arrival cycles whenever out_valid pulses.
module tb_neuron_mac;

    localparam int N    = 16;
    localparam int LEN  = 3;
    localparam int FRAC = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  in_valid;
    logic [N-1:0]          x;
    logic [LEN-1:0][N-1:0] w;
    logic [N-1:0]          bias;
    logic [N-1:0]          out1, out0;
    logic                  ov1, ov0, busy1, busy0;

    always #5 clk = ~clk;

    neuron_mac #(.N(N), .LEN(LEN), .FRAC(FRAC), .RELU(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .x(x),
        .weights(w), .bias(bias), .out(out1), .out_valid(ov1), .busy(busy1));

    neuron_mac #(.N(N), .LEN(LEN), .FRAC(FRAC), .RELU(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .x(x),
        .weights(w), .bias(bias), .out(out0), .out_valid(ov0), .busy(busy0));

    typedef struct {
        logic [N-1:0] val;
        int           when;
    } exp_t;

    int     tests = 0;
    int     fails = 0;
    int     cyc   = 0;
    exp_t   q1[$];
    exp_t   q0[$];

    bit           m_active = 1'b0;
    int           m_idx    = 0;
    longint       m_acc    = 0;
    bit           dir_mode = 1'b0;
    logic [N-1:0] dir1, dir0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact dot product plus scaled bias, floor-divide, clamp, optional ReLU.
    function automatic logic [N-1:0] ref_out(input longint dot, input logic [N-1:0] b, input bit relu);
        longint s;
        longint r;
        s = dot + longint'($signed(b)) * (64'sd1 <<< FRAC);
        r = s >>> FRAC;
        if (r > 64'sd32767)  r = 64'sd32767;
        if (r < -64'sd32768) r = -64'sd32768;
        if (relu && r < 0)   r = 0;
        return r[N-1:0];
    endfunction

    task automatic push_expected(input int when);
        exp_t e;
        e.when = when;
        e.val  = dir_mode ? dir1 : ref_out(m_acc, bias, 1'b1);
        q1.push_back(e);
        e.val  = dir_mode ? dir0 : ref_out(m_acc, bias, 1'b0);
        q0.push_back(e);
    endtask

    // One clock of stimulus, mirrored into the pass model.
    task automatic cycle(input bit st, input bit v, input logic [N-1:0] xv);
        @(negedge clk);
        start    = st;
        in_valid = v;
        x        = xv;
        if (st) begin
            m_active = 1'b1;
            m_idx    = 0;
            m_acc    = 0;
        end else if (v && m_active) begin
            m_acc += longint'($signed(xv)) * longint'($signed(w[m_idx]));
            m_idx++;
            if (m_idx == LEN) begin
                m_active = 1'b0;
                push_expected(cyc + 2);
            end
        end
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        m_active = 1'b0;
        @(negedge clk);
        if (chk) begin
            check("rst_out",       {16'd0, out1}, 32'd0);
            check("rst_out_valid", {31'd0, ov1},  32'd0);
            check("rst_busy",      {30'd0, busy1, busy0}, 32'd0);
        end
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
    endtask

    // Monitor: every out_valid pulse must match the head of its queue, value and cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (ov1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL relu_unexpected_valid: got out=0x%0h with nothing expected (cycle %0d)", out1, cyc);
            end else begin
                e = q1.pop_front();
                check("relu_out", {16'd0, out1}, {16'd0, e.val});
                check("relu_latency", cyc, e.when);
            end
        end
        if (ov0) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL lin_unexpected_valid: got out=0x%0h with nothing expected (cycle %0d)", out0, cyc);
            end else begin
                e = q0.pop_front();
                check("lin_out", {16'd0, out0}, {16'd0, e.val});
                check("lin_latency", cyc, e.when);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; x = '0; w = '0; bias = '0;
        dir1 = '0; dir0 = '0;
        repeat (2) @(negedge clk);
        check("reset_out",       {16'd0, out1}, 32'd0);
        check("reset_out_valid", {30'd0, ov1, ov0}, 32'd0);
        check("reset_busy",      {30'd0, busy1, busy0}, 32'd0);
        rst = 1'b0;

        // Directed: back-to-back samples, 1.0 + 2.0 - 1.0 + 0.5 bias = 2.5
        dir_mode = 1'b1;
        w = {16'hFF00, 16'h0200, 16'h0100}; bias = 16'h0080;
        dir1 = 16'h0280; dir0 = 16'h0280;
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < LEN; i++) cycle(1'b0, 1'b1, 16'h0100);
        idle(4);
        check("hold_out", {16'd0, out1}, 32'h0280);
        check("idle_busy", {30'd0, busy1, busy0}, 32'd0);

        // Directed: two stall cycles between samples, busy held
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < LEN; i++) begin
            cycle(1'b0, 1'b1, 16'h0100);
            if (i < LEN - 1) begin
                for (int g = 0; g < 2; g++) begin
                    cycle(1'b0, 1'b0, 16'h7777);
                    check("stall_busy", {30'd0, busy1, busy0}, 32'h3);
                end
            end
        end
        idle(3);

        // Directed: negative result, ReLU clamps to 0, linear gives -3.0
        w = {16'h0100, 16'h0100, 16'h0100}; bias = 16'h0000;
        dir1 = 16'h0000; dir0 = 16'hFD00;
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < LEN; i++) cycle(1'b0, 1'b1, 16'hFF00);
        idle(3);

        // Directed: positive and negative saturation
        w = {16'h7FFF, 16'h7FFF, 16'h7FFF}; bias = 16'h7FFF;
        dir1 = 16'h7FFF; dir0 = 16'h7FFF;
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < LEN; i++) cycle(1'b0, 1'b1, 16'h7FFF);
        idle(3);
        w = {16'h8000, 16'h8000, 16'h8000}; bias = 16'h0000;
        dir1 = 16'h0000; dir0 = 16'h8000;
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < LEN; i++) cycle(1'b0, 1'b1, 16'h7FFF);
        idle(3);

        // Directed: restart with a same-cycle sample; that sample must be dropped
        w = {16'hFF00, 16'h0200, 16'h0100}; bias = 16'h0080;
        dir1 = 16'h0280; dir0 = 16'h0280;
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 16'h0400);
        cycle(1'b0, 1'b1, 16'h0400);
        cycle(1'b1, 1'b1, 16'h7FFF);
        for (int i = 0; i < LEN; i++) cycle(1'b0, 1'b1, 16'h0100);
        idle(3);

        // Directed: reset mid-pass, then samples in IDLE must do nothing
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 16'h0100);
        cycle(1'b0, 1'b1, 16'h0100);
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'h0100);
        idle(3);
        check("idle_after_rst_busy", {30'd0, busy1, busy0}, 32'd0);

        // Randomized passes with stalls, aborts and resets
        dir_mode = 1'b0;
        for (int p = 0; p < 80; p++) begin
            int mode;
            for (int i = 0; i < LEN; i++) begin
                logic [31:0] r;
                r = $urandom;
                w[i] = p[0] ? {{8{r[7]}}, r[7:0]} : r[15:0];
            end
            bias = 16'($urandom);
            mode = $urandom_range(0, 9);
            cycle(1'b1, 1'b0, '0);
            if (mode == 0) begin
                cycle(1'b0, 1'b1, 16'($urandom));
                cycle(1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
            end else if (mode == 1) begin
                cycle(1'b0, 1'b1, 16'($urandom));
                do_reset(1'b0);
                cycle(1'b1, 1'b0, '0);
            end
            for (int s = 0; s < LEN; s++) begin
                int gaps;
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) cycle(1'b0, 1'b0, 16'($urandom));
                cycle(1'b0, 1'b1, p[1] ? {{8{1'b0}}, 8'($urandom)} : 16'($urandom));
            end
            cycle(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
            cycle(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
        end

        idle(5);
        check("queue_drain", q1.size() + q0.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
